alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Initiator side of the ALU `alu_valid`/`alu_ready` handshake. Accepts one decoded operation per transaction from the control path and drives the ALU operand and control lines. Holds `alu_valid` until the ALU answers, then captures the result and presents it as a writeback or branch decision with its own valid/ready handshake. Sits between the multicycle controller and the ALU. Makes single-cycle and cycle-based-shifter ALU builds look identical to the controller.

## Interface
Parameters:
- `MAX_WAIT`, default 40: cycles in ISSUE without `alu_ready` before abort. Must be ≥ 33, the worst-case cycle-based shift.

Ports. One clock; reset is asynchronous and active-low.
- `clk`  in  1  clock
- `resetn`  in  1  asynchronous active-low reset
- `req_valid`  in  1  operation offered
- `req_ready`  out  1  operation accepted this cycle
- `req_a`, `req_b`  in  32  operands
- `req_ctrl`  in  `ALU_CTRL_WIDTH`  ALU control code
- `req_rd`  in  5  destination register
- `alu_a`, `alu_b`  out  32  registered operands to ALU
- `alucontrol`  out  `ALU_CTRL_WIDTH`  registered control to ALU
- `alu_valid`  out  1  request to ALU
- `alu_ready`  in  1  ALU result valid this cycle
- `alu_result`  in  32  ALU result
- `wb_valid`  out  1  response available
- `wb_ready`  in  1  response consumed
- `wb_data`  out  32  captured result; 0 for branches and errors
- `wb_rd`  out  5  destination; 0 for branches
- `wb_we`  out  1  register write enable
- `branch_taken`  out  1  captured `alu_result[0]` for branch codes
- `wb_err`  out  1  transaction aborted by timeout

## Operation
- **States:**
  - IDLE: `req_ready`=1.
  - ISSUE: `alu_valid`=1.
  - RESP: `wb_valid`=1.
- **IDLE → ISSUE** on `req_valid`. Latch `req_a`, `req_b`, `req_ctrl`, `req_rd`. Latch `is_branch` (code ∈ BEQ, BNE, BLT, BGE, BLTU, BGEU). Clear the wait counter.
- **ISSUE:**
  - Operand and control outputs stay stable for the whole state.
  - On `alu_ready`: capture the result and go to RESP.
  - For branches: `branch_taken`=`alu_result[0]`, `wb_we`=0, `wb_data`=0, `wb_rd`=0.
  - Otherwise: `wb_we`=1 iff latched rd≠0, `wb_data`=`alu_result`.
- **Timeout:** the wait counter increments each ISSUE cycle without `alu_ready`. When it equals `MAX_WAIT`, go to RESP with `wb_err`=1, `wb_we`=0, `wb_data`=0.
- **RESP:** hold all `wb_*` outputs until `wb_ready`.
  - `wb_ready` and `req_valid` together: accept the new request and go to ISSUE directly (back-to-back).
  - `wb_ready` alone: go to IDLE.
  - `req_ready` = (IDLE) | (RESP & `wb_ready`).
- **Valid-drop rule:** `alu_valid` is low for at least one cycle between transactions. This is required so the cycle-based shifter re-arms. RESP always lasts ≥1 cycle, which guarantees it.
- `alu_valid` is never asserted outside ISSUE. `alu_ready` outside ISSUE is ignored.

## Timing
- **Reset values** (async, immediate): state IDLE; `alu_valid`, `wb_valid`, `wb_we`, `wb_err`, `branch_taken` = 0; `alu_a`, `alu_b`, `alucontrol`, `wb_data`, `wb_rd` = 0; `req_ready`=1 once `resetn` is high.
- **Latency:**
  - Request accepted at edge 0. `alu_valid` high in cycle 1.
  - Combinational ALU answers in cycle 1, so `wb_valid` is high in cycle 2.
  - Cycle-based shift by n>0 (`alu_ready` in cycle n+2): `wb_valid` in cycle n+3.
  - Shift by 0: `wb_valid` in cycle 3.
- **Throughput:** one transaction per 2 cycles minimum with a combinational ALU and `wb_ready` tied high.
- **Timeout vs. ready:** `alu_ready` in the same cycle the counter reaches `MAX_WAIT` wins (normal completion, `wb_err`=0).
- **Reset mid-ISSUE:** `alu_valid` drops asynchronously and no response is produced. The ALU shifter is reset by the same `resetn`.

## Structure
- `ALU_CTRL_WIDTH` and all `ALU_CTRL_*` codes come from `riscv_defines.vh`. Add a shared macro there listing the six branch codes, rather than redefining them locally.
- State encoding is local (2 bits).
- No sub-modules. The wait counter is `$clog2(MAX_WAIT+1)` bits, inline.

## Test plan
- **ADD:** `req_a`=5, `req_b`=7, rd=3, combinational ALU → `alu_valid` cycle 1 only; `wb_valid` cycle 2; `wb_data`=12, `wb_rd`=3, `wb_we`=1.
- **Cycle-based SLL:** a=1, b=5 → `alu_valid` held cycles 1–7; `wb_data`=0x20 in cycle 8; `alu_valid` low in cycle 8.
- **Branches:**
  - BEQ a=b=9 → `branch_taken`=1, `wb_we`=0, `wb_data`=0.
  - BLTU a=3, b=2 → `branch_taken`=0.
- **Backpressure:** `wb_ready` low 4 cycles with `req_valid` high → `wb_*` stable, `req_ready`=0. On `wb_ready`, the next request is issued the following cycle, with `alu_valid` having been low ≥1 cycle.
- **Timeout:** ALU stub never asserts ready, `MAX_WAIT`=40 → after 40 ISSUE cycles `wb_valid`=1, `wb_err`=1, `wb_we`=0, `alu_valid`=0.
- **Reset mid-ISSUE:** `resetn` low during cycle 3 of a shift → `alu_valid`=0 immediately; after release, `req_ready`=1 and no `wb_valid` for the aborted transaction.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU control definitions for the issue controller and its users.
// Holds the ALU control code width, the individual control codes, and the
// list of branch-comparison codes in one place so no block redefines them.
package alu_issue_ctrl_pkg;

  localparam int unsigned ALU_CTRL_WIDTH = 4;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_ADD  = 4'd0;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SUB  = 4'd1;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SLL  = 4'd2;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SLT  = 4'd3;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SLTU = 4'd4;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_XOR  = 4'd5;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SRL  = 4'd6;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_SRA  = 4'd7;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_OR   = 4'd8;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_AND  = 4'd9;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BEQ  = 4'd10;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BNE  = 4'd11;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BLT  = 4'd12;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BGE  = 4'd13;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BLTU = 4'd14;
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_CTRL_BGEU = 4'd15;

  // The single shared list of branch-comparison codes.
  function automatic logic is_branch_code(input logic [ALU_CTRL_WIDTH-1:0] code);
    return code inside {ALU_CTRL_BEQ, ALU_CTRL_BNE, ALU_CTRL_BLT,
                        ALU_CTRL_BGE, ALU_CTRL_BLTU, ALU_CTRL_BGEU};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the ALU valid/ready handshake.
// Accepts one decoded operation from the controller, drives registered operands
// and control to the ALU while holding alu_valid, then captures the result and
// presents it as a writeback or branch decision on its own valid/ready port.
// Single-cycle and cycle-based-shifter ALUs look identical to the controller.
//
// Ports:
//   clk, resetn                       clock, asynchronous active-low reset
//   req_valid/req_ready               operation handshake from controller
//   req_a, req_b, req_ctrl, req_rd    operands, ALU code, destination register
//   alu_a, alu_b, alucontrol          registered operands/control to the ALU
//   alu_valid/alu_ready, alu_result   ALU request handshake and result
//   wb_valid/wb_ready                 response handshake
//   wb_data, wb_rd, wb_we             writeback payload
//   branch_taken                      branch decision (alu_result[0])
//   wb_err                            transaction aborted by timeout
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 40
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_a,
  input  logic [31:0]               req_b,
  input  logic [ALU_CTRL_WIDTH-1:0] req_ctrl,
  input  logic [4:0]                req_rd,
  output logic [31:0]               alu_a,
  output logic [31:0]               alu_b,
  output logic [ALU_CTRL_WIDTH-1:0] alucontrol,
  output logic                      alu_valid,
  input  logic                      alu_ready,
  input  logic [31:0]               alu_result,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [31:0]               wb_data,
  output logic [4:0]                wb_rd,
  output logic                      wb_we,
  output logic                      branch_taken,
  output logic                      wb_err
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [31:0]               a_q, a_d;
  logic [31:0]               b_q, b_d;
  logic [ALU_CTRL_WIDTH-1:0] ctrl_q, ctrl_d;
  logic [4:0]                rd_q, rd_d;
  logic                      is_br_q, is_br_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [31:0]               wb_data_q, wb_data_d;
  logic [4:0]                wb_rd_q, wb_rd_d;
  logic                      wb_we_q, wb_we_d;
  logic                      taken_q, taken_d;
  logic                      err_q, err_d;

  logic                      accept;
  logic [CntW-1:0]           cnt_inc;

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    ctrl_d    = ctrl_q;
    rd_d      = rd_q;
    is_br_d   = is_br_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    wb_rd_d   = wb_rd_q;
    wb_we_d   = wb_we_q;
    taken_d   = taken_q;
    err_d     = err_q;
    accept    = 1'b0;

    unique case (state_q)
      StIdle: begin
        accept = req_valid;
      end
      StIssue: begin
        // A ready arriving in the cycle the counter would expire still wins.
        if (alu_ready) begin
          state_d = StResp;
          err_d   = 1'b0;
          if (is_br_q) begin
            taken_d   = alu_result[0];
            wb_we_d   = 1'b0;
            wb_data_d = '0;
            wb_rd_d   = '0;
          end else begin
            taken_d   = 1'b0;
            wb_we_d   = (rd_q != 5'd0);
            wb_data_d = alu_result;
            wb_rd_d   = rd_q;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntW'(MAX_WAIT)) begin
            state_d   = StResp;
            err_d     = 1'b1;
            taken_d   = 1'b0;
            wb_we_d   = 1'b0;
            wb_data_d = '0;
            wb_rd_d   = is_br_q ? 5'd0 : rd_q;
          end
        end
      end
      StResp: begin
        if (wb_ready) begin
          if (req_valid) begin
            accept = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Accepting always passes through ISSUE, so alu_valid has dropped for at
    // least the RESP/IDLE cycle before the next assertion.
    if (accept) begin
      state_d = StIssue;
      a_d     = req_a;
      b_d     = req_b;
      ctrl_d  = req_ctrl;
      rd_d    = req_rd;
      is_br_d = is_branch_code(req_ctrl);
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      ctrl_q    <= '0;
      rd_q      <= '0;
      is_br_q   <= 1'b0;
      cnt_q     <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_we_q   <= 1'b0;
      taken_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ctrl_q    <= ctrl_d;
      rd_q      <= rd_d;
      is_br_q   <= is_br_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_we_q   <= wb_we_d;
      taken_q   <= taken_d;
      err_q     <= err_d;
    end
  end

  // Valids decode straight from state so reset drops them asynchronously.
  assign alu_valid    = (state_q == StIssue);
  assign wb_valid     = (state_q == StResp);
  assign req_ready    = (state_q == StIdle) | ((state_q == StResp) & wb_ready);
  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alucontrol   = ctrl_q;
  assign wb_data      = wb_data_q;
  assign wb_rd        = wb_rd_q;
  assign wb_we        = wb_we_q;
  assign branch_taken = taken_q;
  assign wb_err       = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  localparam int unsigned MaxWait = 40;

  logic                      clk = 1'b0;
  logic                      resetn = 1'b0;
  logic                      req_valid = 1'b0;
  logic                      req_ready;
  logic [31:0]               req_a = '0;
  logic [31:0]               req_b = '0;
  logic [ALU_CTRL_WIDTH-1:0] req_ctrl = '0;
  logic [4:0]                req_rd = '0;
  logic [31:0]               alu_a, alu_b;
  logic [ALU_CTRL_WIDTH-1:0] alucontrol;
  logic                      alu_valid, alu_ready;
  logic [31:0]               alu_result;
  logic                      wb_valid;
  logic                      wb_ready = 1'b0;
  logic [31:0]               wb_data;
  logic [4:0]                wb_rd;
  logic                      wb_we, branch_taken, wb_err;

  alu_issue_ctrl #(.MAX_WAIT(MaxWait)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ctrl    (req_ctrl),
    .req_rd      (req_rd),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alucontrol  (alucontrol),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .wb_we       (wb_we),
    .branch_taken(branch_taken),
    .wb_err      (wb_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: event did not occur as required (t=%0t)", name, $time);
  endtask

  // ---------------- reference model (arithmetic from the ALU definitions) ----
  function automatic logic [31:0] ref_alu(input logic [ALU_CTRL_WIDTH-1:0] c,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (c)
      ALU_CTRL_ADD:  return a + b;
      ALU_CTRL_SUB:  return a - b;
      ALU_CTRL_SLL:  return a << sh;
      ALU_CTRL_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_CTRL_SLTU: return {31'd0, a < b};
      ALU_CTRL_XOR:  return a ^ b;
      ALU_CTRL_SRL:  return a >> sh;
      ALU_CTRL_SRA:  return 32'($signed(a) >>> sh);
      ALU_CTRL_OR:   return a | b;
      ALU_CTRL_AND:  return a & b;
      ALU_CTRL_BEQ:  return {31'd0, a == b};
      ALU_CTRL_BNE:  return {31'd0, a != b};
      ALU_CTRL_BLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_CTRL_BGE:  return {31'd0, $signed(a) >= $signed(b)};
      ALU_CTRL_BLTU: return {31'd0, a < b};
      default:       return {31'd0, a >= b};
    endcase
  endfunction

  function automatic bit tb_is_shift(input logic [ALU_CTRL_WIDTH-1:0] c);
    return (c == ALU_CTRL_SLL) || (c == ALU_CTRL_SRL) || (c == ALU_CTRL_SRA);
  endfunction

  function automatic bit tb_is_branch(input logic [ALU_CTRL_WIDTH-1:0] c);
    return c >= ALU_CTRL_BEQ;
  endfunction

  // ---------------- ALU stub: combinational ops, cycle-based shifter ---------
  // req_lat overrides the answer cycle (0 = natural latency, huge = never).
  int req_lat = 0;
  int lat_q = 0;
  int issue_cyc = 0;
  int need;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) issue_cyc <= 0;
    else if (alu_valid) issue_cyc <= issue_cyc + 1;
    else issue_cyc <= 0;
  end

  always @(posedge clk) begin
    if (req_valid && req_ready) lat_q <= req_lat;
  end

  always_comb begin
    need = tb_is_shift(alucontrol) ? int'(alu_b[4:0]) + 2 : 1;
    if (lat_q != 0) need = lat_q;
  end

  assign alu_ready  = alu_valid && (issue_cyc + 1 == need);
  assign alu_result = alu_ready ? ref_alu(alucontrol, alu_a, alu_b) : 32'hDEAD_BEEF;

  // ---------------- scoreboard ------------------------------------------------
  typedef struct {
    logic [31:0]               a;
    logic [31:0]               b;
    logic [ALU_CTRL_WIDTH-1:0] ctrl;
    logic [31:0]               data;
    logic [4:0]                rd;
    logic                      we;
    logic                      taken;
    logic                      err;
    int                        len;
  } exp_t;

  exp_t sb_q[$];

  int bp_mode = 2;  // 0 random wb_ready, 1 held low, 2 held high

  initial begin
    forever begin
      @(negedge clk);
      case (bp_mode)
        0:       wb_ready = ($urandom_range(0, 3) != 0);
        1:       wb_ready = 1'b0;
        default: wb_ready = 1'b1;
      endcase
    end
  end

  task automatic send(input logic [ALU_CTRL_WIDTH-1:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd, input int lat);
    exp_t e;
    int   eff;
    int   guard;
    logic [31:0] r;
    @(negedge clk);
    req_valid = 1'b1;
    req_ctrl  = c;
    req_a     = a;
    req_b     = b;
    req_rd    = rd;
    req_lat   = lat;
    r   = ref_alu(c, a, b);
    eff = (lat != 0) ? lat : (tb_is_shift(c) ? int'(b[4:0]) + 2 : 1);
    e.a = a; e.b = b; e.ctrl = c;
    if (eff > int'(MaxWait)) begin
      e.len = MaxWait; e.err = 1'b1; e.we = 1'b0; e.data = '0; e.taken = 1'b0;
      e.rd  = tb_is_branch(c) ? 5'd0 : rd;
    end else if (tb_is_branch(c)) begin
      e.len = eff; e.err = 1'b0; e.we = 1'b0; e.data = '0; e.taken = r[0]; e.rd = 5'd0;
    end else begin
      e.len = eff; e.err = 1'b0; e.we = (rd != 5'd0); e.data = r; e.taken = 1'b0; e.rd = rd;
    end
    guard = 0;
    #1;
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!req_ready) begin
      fail("req_accept_timeout");
      req_valid = 1'b0;
    end else begin
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) fail("drain_timeout");
  endtask

  // ---------------- monitor ---------------------------------------------------
  int mon_len = 0;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!resetn) begin
        mon_len = 0;
      end else begin
        chk("req_ready_rule", 32'(req_ready), 32'(!alu_valid && (!wb_valid || wb_ready)));
        chk("valid_overlap", 32'(alu_valid && wb_valid), 32'd0);
        if (alu_valid) begin
          mon_len++;
          if (sb_q.size() == 0) fail("issue_without_request");
          else begin
            chk("alu_a", alu_a, sb_q[0].a);
            chk("alu_b", alu_b, sb_q[0].b);
            chk("alucontrol", 32'(alucontrol), 32'(sb_q[0].ctrl));
          end
        end
        if (wb_valid) begin
          if (sb_q.size() == 0) fail("wb_without_request");
          else begin
            chk("wb_data", wb_data, sb_q[0].data);
            chk("wb_rd", 32'(wb_rd), 32'(sb_q[0].rd));
            chk("wb_we", 32'(wb_we), 32'(sb_q[0].we));
            chk("branch_taken", 32'(branch_taken), 32'(sb_q[0].taken));
            chk("wb_err", 32'(wb_err), 32'(sb_q[0].err));
            chk("issue_len", 32'(mon_len), 32'(sb_q[0].len));
            if (wb_ready) begin
              void'(sb_q.pop_front());
              mon_len = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- main sequence ---------------------------------------------
  initial begin
    logic [ALU_CTRL_WIDTH-1:0] c;
    logic [31:0] a, b;
    logic [4:0]  rd;
    int          lat;

    #7;
    chk("rst_alu_valid", 32'(alu_valid), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_wb_err", 32'(wb_err), 32'd0);
    chk("rst_branch_taken", 32'(branch_taken), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alucontrol", 32'(alucontrol), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    #16;
    resetn = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    bp_mode = 2;
    send(ALU_CTRL_ADD, 32'd5, 32'd7, 5'd3, 0);
    send(ALU_CTRL_SLL, 32'd1, 32'd5, 5'd7, 0);
    send(ALU_CTRL_SLL, 32'h1234, 32'd0, 5'd8, 0);
    send(ALU_CTRL_BEQ, 32'd9, 32'd9, 5'd4, 0);
    send(ALU_CTRL_BLTU, 32'd3, 32'd2, 5'd5, 0);
    send(ALU_CTRL_ADD, 32'd1, 32'd1, 5'd0, 0);
    wait_drain();

    // Backpressure: response held four cycles while the next request waits.
    bp_mode = 1;
    send(ALU_CTRL_ADD, 32'd100, 32'd23, 5'd9, 0);
    fork
      send(ALU_CTRL_SUB, 32'd50, 32'd8, 5'd10, 0);
      begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          #3;
          chk("bp_req_ready", 32'(req_ready), 32'd0);
          chk("bp_wb_valid", 32'(wb_valid), 32'd1);
          chk("bp_wb_data", wb_data, 32'd123);
        end
        bp_mode = 2;
      end
    join
    wait_drain();

    // Timeout and the ready-versus-timeout boundary.
    send(ALU_CTRL_ADD, 32'd1, 32'd2, 5'd6, 1000);
    send(ALU_CTRL_XOR, 32'hF0F0, 32'h0FF0, 5'd11, 40);
    send(ALU_CTRL_OR, 32'h1, 32'h2, 5'd12, 41);
    send(ALU_CTRL_BNE, 32'd1, 32'd2, 5'd13, 1000);
    wait_drain();

    // Reset in the third ISSUE cycle of a long shift.
    send(ALU_CTRL_SLL, 32'd3, 32'd20, 5'd1, 0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("midrst_alu_valid", 32'(alu_valid), 32'd0);
    chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    #3;
    resetn = 1'b1;
    #1;
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #3;
      chk("midrst_no_wb", 32'(wb_valid), 32'd0);
    end

    // Randomized traffic with random backpressure and occasional forced latency.
    bp_mode = 0;
    for (int n = 0; n < 250; n++) begin
      c  = 4'($urandom_range(0, 15));
      a  = $urandom();
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lat = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 45) : 0;
      if ($urandom_range(0, 2) == 0) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge clk);
      end
      send(c, a, b, rd, lat);
    end
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
